// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM state encoding, SPI mode and counter sizing.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        XFER  = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } spi_state_t;

    // Mode 0: SCLK idles low, data sampled on the leading (rising) edge.
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    // Bits needed for a counter that must be able to hold max_count itself.
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCLK generator: divides clk by 2*CLK_DIV while enabled and flags the edge about to be produced.
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic sclk_o,
    output logic rise_tick_o,
    output logic fall_tick_o
);

    localparam int            CW       = cnt_width(CLK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sclk_q, sclk_d;
    logic          term;

    assign term = en_i && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        if (!en_i) begin
            cnt_d  = '0;
            sclk_d = SPI_CPOL;
        end else if (term) begin
            cnt_d  = '0;
            sclk_d = ~sclk_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            sclk_q <= SPI_CPOL;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    // Ticks are asserted in the cycle whose closing edge moves SCLK.
    assign sclk_o      = sclk_q;
    assign rise_tick_o = term && !sclk_q;
    assign fall_tick_o = term && sclk_q;

endmodule

// File: rtl/spi_master_ctrl.sv
// Mode-0 SPI master: sequences chip select, SCLK and the MOSI/MISO shift registers for one word per start.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  start_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  miso_in,
    output logic                  busy_out,
    output logic                  done_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  sclk_out,
    output logic                  mosi_out,
    output logic                  cs_n_out
);

    localparam int             DCW        = cnt_width(CLK_DIV);
    localparam int             BCW        = cnt_width(DATA_WIDTH);
    localparam logic [DCW-1:0] SETUP_LAST = DCW'(CLK_DIV);
    localparam logic [DCW-1:0] HOLD_LAST  = DCW'(CLK_DIV - 1);
    localparam logic [BCW-1:0] BIT_LAST   = BCW'(DATA_WIDTH);

    spi_state_t            state_q;
    logic [DCW-1:0]        phase_q;
    logic [BCW-1:0]        bit_q;
    logic [DATA_WIDTH-1:0] tx_shift_q;
    logic [DATA_WIDTH-1:0] rx_shift_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  mosi_q;
    logic                  cs_n_q;

    logic div_en;
    logic rise_tick;
    logic fall_tick;
    logic sample_tick;
    logic shift_tick;

    assign div_en = (state_q == XFER);

    spi_clk_div #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_div (
        .clk_i      (clk_in),
        .rst_i      (rst_in),
        .en_i       (div_en),
        .sclk_o     (sclk_out),
        .rise_tick_o(rise_tick),
        .fall_tick_o(fall_tick)
    );

    assign sample_tick = (SPI_CPHA == 1'b0) ? rise_tick : fall_tick;
    assign shift_tick  = (SPI_CPHA == 1'b0) ? fall_tick : rise_tick;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            bit_q      <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_in) begin
                        tx_shift_q <= data_in;
                        rx_shift_q <= '0;
                        bit_q      <= '0;
                        phase_q    <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= SETUP;
                    end
                end
                SETUP: begin
                    // Entry cycle drops cs_n; CLK_DIV further cycles of setup precede SCLK.
                    cs_n_q <= 1'b0;
                    mosi_q <= tx_shift_q[DATA_WIDTH-1];
                    if (phase_q == SETUP_LAST) begin
                        phase_q <= '0;
                        state_q <= XFER;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                XFER: begin
                    if (sample_tick) begin
                        rx_shift_q <= {rx_shift_q[DATA_WIDTH-2:0], miso_in};
                        bit_q      <= bit_q + 1'b1;
                    end
                    if (shift_tick) begin
                        if (bit_q == BIT_LAST) begin
                            phase_q <= '0;
                            state_q <= HOLD;
                        end else begin
                            tx_shift_q <= {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                            mosi_q     <= tx_shift_q[DATA_WIDTH-2];
                        end
                    end
                end
                HOLD: begin
                    if (phase_q == HOLD_LAST) begin
                        phase_q <= '0;
                        cs_n_q  <= 1'b1;
                        done_q  <= 1'b1;
                        data_q  <= rx_shift_q;
                        state_q <= DONE;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_out = busy_q;
    assign done_out = done_q;
    assign data_out = data_q;
    assign mosi_out = mosi_q;
    assign cs_n_out = cs_n_q;

endmodule
